store_narrow_unit: RTL and testbench



---
 rtl/mem_defs.sv | 21 ++
 rtl/store_lane_mapper.sv | 44 ++++
 rtl/store_narrow_unit.sv | 151 +++++++++++++++
 tb/tb_store_narrow_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_defs.sv
// Shared encodings for the store narrowing path: access sizes, completion
// status codes and the store FSM state type.
package mem_defs;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  localparam logic [1:0] STATUS_OK       = 2'b00;
  localparam logic [1:0] STATUS_MISALIGN = 2'b01;
  localparam logic [1:0] STATUS_BADSIZE  = 2'b10;
  localparam logic [1:0] STATUS_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/store_lane_mapper.sv
// Combinational lane mapper: turns size/low address bits into byte enables,
// lane-replicated write data and alignment/size error flags.
module store_lane_mapper
  import mem_defs::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] data,
  output logic        misalign,
  output logic        badsize
);

  always_comb begin
    be       = 4'b0000;
    data     = 32'h0000_0000;
    misalign = 1'b0;
    badsize  = 1'b0;
    case (size)
      SIZE_BYTE: begin
        // Big-endian puts byte offset 0 in the most significant lane.
        be   = BIG_ENDIAN ? (4'b1000 >> addr_lo) : (4'b0001 << addr_lo);
        data = {4{wdata[7:0]}};
      end
      SIZE_HALF: begin
        be       = (addr_lo[1] ^ BIG_ENDIAN) ? 4'b1100 : 4'b0011;
        data     = {2{wdata[15:0]}};
        misalign = addr_lo[0];
      end
      SIZE_WORD: begin
        be       = 4'b1111;
        data     = wdata;
        misalign = (addr_lo != 2'b00);
      end
      default: begin
        badsize = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: validates a store, drives lane-replicated data and
// byte enables over a req/ack handshake and reports one status per store.
module store_narrow_unit
  import mem_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter bit          BIG_ENDIAN     = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack
);

  localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  status_q, status_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_data;
  logic        lane_misalign;
  logic        lane_badsize;

  store_lane_mapper #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_lane_mapper (
    .addr_lo  (addr[1:0]),
    .size     (size),
    .wdata    (wdata),
    .be       (lane_be),
    .data     (lane_data),
    .misalign (lane_misalign),
    .badsize  (lane_badsize)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    status_d    = status_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (lane_badsize) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            status_d = STATUS_BADSIZE;
          end else if (lane_misalign) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            status_d = STATUS_MISALIGN;
          end else begin
            state_d     = ST_REQ;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wdata_d = lane_data;
            mem_be_d    = lane_be;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Ack is checked before the timeout so a last-cycle ack still succeeds.
        if (mem_ack) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          status_d  = STATUS_OK;
          mem_req_d = 1'b0;
          mem_be_d  = 4'b0000;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          status_d  = STATUS_TIMEOUT;
          mem_req_d = 1'b0;
          mem_be_d  = 4'b0000;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_be_d  = 4'b0000;
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_be_d  = 4'b0000;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      mem_be_q    <= 4'b0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      status_q    <= status_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign status    = status_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Scoreboard bench for store_narrow_unit: one little-endian and one
// big-endian instance, expected stores queued at start and checked on output.
module tb_store_narrow_unit;
  import mem_defs::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_le = 1'b0;
  logic        start_be = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [1:0]  size = 2'b00;
  logic        sel = 1'b0;

  logic        le_busy, le_done, le_req, be_busy, be_done, be_req;
  logic [1:0]  le_status, be_status;
  logic [31:0] le_addr, le_wdata, be_addr, be_wdata;
  logic [3:0]  le_be, be_be;

  logic        o_busy, o_done, o_req;
  logic [1:0]  o_status;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_be;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          req_cycles;
    logic [1:0]  status;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   req_cnt = 0;

  store_narrow_unit #(.TIMEOUT_CYCLES(TO), .BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .rst_n(rst_n), .start(start_le), .addr(addr), .wdata(wdata),
    .size(size), .busy(le_busy), .done(le_done), .status(le_status),
    .mem_req(le_req), .mem_addr(le_addr), .mem_wdata(le_wdata),
    .mem_be(le_be), .mem_ack(mem_ack)
  );

  store_narrow_unit #(.TIMEOUT_CYCLES(TO), .BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .rst_n(rst_n), .start(start_be), .addr(addr), .wdata(wdata),
    .size(size), .busy(be_busy), .done(be_done), .status(be_status),
    .mem_req(be_req), .mem_addr(be_addr), .mem_wdata(be_wdata),
    .mem_be(be_be), .mem_ack(mem_ack)
  );

  assign o_busy   = sel ? be_busy   : le_busy;
  assign o_done   = sel ? be_done   : le_done;
  assign o_req    = sel ? be_req    : le_req;
  assign o_status = sel ? be_status : le_status;
  assign o_addr   = sel ? be_addr   : le_addr;
  assign o_wdata  = sel ? be_wdata  : le_wdata;
  assign o_be     = sel ? be_be     : le_be;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input bit bige, input logic [31:0] a, input logic [31:0] d,
                                 input logic [1:0] sz, input int ack_at);
    exp_t e;
    int   lane;
    e.addr   = {a[31:2], 2'b00};
    e.data   = 32'h0;
    e.be     = 4'b0000;
    e.status = STATUS_OK;
    case (sz)
      2'b00: begin
        lane   = bige ? 3 - int'(a[1:0]) : int'(a[1:0]);
        e.be   = 4'(1 << lane);
        e.data = {d[7:0], d[7:0], d[7:0], d[7:0]};
      end
      2'b01: begin
        if (a[0]) e.status = STATUS_MISALIGN;
        else begin
          e.data = {d[15:0], d[15:0]};
          e.be   = ((a[1] == 1'b1) != bige) ? 4'b1100 : 4'b0011;
        end
      end
      2'b10: begin
        if (a[1:0] != 2'b00) e.status = STATUS_MISALIGN;
        else begin
          e.data = d;
          e.be   = 4'b1111;
        end
      end
      default: e.status = STATUS_BADSIZE;
    endcase
    if (e.status != STATUS_OK) e.req_cycles = 0;
    else if (ack_at >= 1 && ack_at <= TO) e.req_cycles = ack_at;
    else begin
      e.req_cycles = TO;
      e.status     = STATUS_TIMEOUT;
    end
    return e;
  endfunction

  // Scoreboard monitor: checks request lanes every REQ cycle and pops on done.
  always @(negedge clk) begin
    if (!rst_n) begin
      req_cnt = 0;
    end else begin
      if (o_req) begin
        req_cnt++;
        if (sbq.size() == 0) check_val("req_without_store", {31'h0, o_req}, 32'h0);
        else begin
          check_val("mem_addr", o_addr, sbq[0].addr);
          check_val("mem_wdata", o_wdata, sbq[0].data);
          check_val("mem_be", {28'h0, o_be}, {28'h0, sbq[0].be});
          check_val("busy_in_req", {31'h0, o_busy}, 32'h1);
        end
      end
      if (o_done) begin
        if (sbq.size() == 0) check_val("spurious_done", {31'h0, o_done}, 32'h0);
        else begin
          mon_e = sbq.pop_front();
          check_val("status", {30'h0, o_status}, {30'h0, mon_e.status});
          check_val("req_cycles", req_cnt, mon_e.req_cycles);
          check_val("req_low_at_done", {31'h0, o_req}, 32'h0);
          check_val("be_zero_at_done", {28'h0, o_be}, 32'h0);
        end
        req_cnt = 0;
      end
    end
  end

  task automatic drive_start(input bit bige, input logic v);
    if (bige) start_be = v;
    else      start_le = v;
  endtask

  task automatic do_store(input bit bige, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] sz, input int ack_at, input bit poke);
    exp_t e;
    int   cyc;
    @(posedge clk); #1;
    sel   = bige;
    addr  = a;
    wdata = d;
    size  = sz;
    e     = model(bige, a, d, sz, ack_at);
    sbq.push_back(e);
    drive_start(bige, 1'b1);
    @(posedge clk); #1;
    drive_start(bige, 1'b0);
    cyc = 0;
    while (!o_done && cyc < TO + 8) begin
      cyc++;
      mem_ack = (cyc == ack_at);
      if (poke && cyc == 2) drive_start(bige, 1'b1);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      drive_start(bige, 1'b0);
    end
    if (!o_done) begin
      check_val("done_never_seen", {31'h0, o_done}, 32'h1);
      sbq.delete();
    end else begin
      check_val("latency", cyc, e.req_cycles);
    end
    if (poke) begin
      drive_start(bige, 1'b1);
      @(posedge clk); #1;
      drive_start(bige, 1'b0);
    end
    @(posedge clk); #1;
    check_val("idle_after_store", {31'h0, o_busy}, 32'h0);
  endtask

  task automatic check_le_zero(input string tag);
    check_val({tag, "_busy"}, {31'h0, le_busy}, 32'h0);
    check_val({tag, "_done"}, {31'h0, le_done}, 32'h0);
    check_val({tag, "_req"}, {31'h0, le_req}, 32'h0);
    check_val({tag, "_status"}, {30'h0, le_status}, 32'h0);
    check_val({tag, "_addr"}, le_addr, 32'h0);
    check_val({tag, "_wdata"}, le_wdata, 32'h0);
    check_val({tag, "_be"}, {28'h0, le_be}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_le_zero("reset");
    check_val("reset_be_inst_req", {31'h0, be_req}, 32'h0);
    check_val("reset_be_inst_busy", {31'h0, be_busy}, 32'h0);
    rst_n = 1'b1;

    do_store(1'b0, 32'h0000_1003, 32'hAABB_CCDD, SIZE_BYTE, 4, 1'b0);
    do_store(1'b1, 32'h0000_2002, 32'h1234_5678, SIZE_HALF, 1, 1'b0);
    do_store(1'b0, 32'h0000_3001, 32'hCAFE_F00D, SIZE_WORD, 1, 1'b0);
    do_store(1'b0, 32'h0000_0000, 32'hCAFE_F00D, SIZE_ILLEGAL, 1, 1'b0);
    do_store(1'b0, 32'h0000_2001, 32'h1234_5678, SIZE_HALF, 1, 1'b0);
    do_store(1'b0, 32'h0000_4000, 32'h0BAD_BEEF, SIZE_WORD, 0, 1'b0);
    do_store(1'b0, 32'h0000_4000, 32'h0BAD_BEEF, SIZE_WORD, TO, 1'b0);
    do_store(1'b0, 32'h0000_5002, 32'h8765_4321, SIZE_HALF, 3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      do_store(1'b0, 32'h8000_0010 + 32'(i), 32'h1122_3344 + 32'(i), SIZE_BYTE, 1 + i, 1'b0);
      do_store(1'b1, 32'h8000_0010 + 32'(i), 32'h5566_7788 + 32'(i), SIZE_BYTE, 2, 1'b0);
    end
    do_store(1'b0, 32'hFFFF_FFFE, 32'hDEAD_BEEF, SIZE_HALF, 2, 1'b0);
    do_store(1'b1, 32'h0000_0000, 32'hDEAD_BEEF, SIZE_HALF, 2, 1'b0);
    do_store(1'b1, 32'h0000_0104, 32'h0102_0304, SIZE_WORD, 5, 1'b0);

    // Reset while a store is waiting for its ack.
    @(posedge clk); #1;
    sel   = 1'b0;
    addr  = 32'h0000_6004;
    wdata = 32'h5A5A_A5A5;
    size  = SIZE_WORD;
    sbq.push_back(model(1'b0, addr, wdata, size, 0));
    start_le = 1'b1;
    @(posedge clk); #1;
    start_le = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("req_before_reset", {31'h0, le_req}, 32'h1);
    rst_n = 1'b0;
    sbq.delete();
    @(posedge clk); #1;
    check_le_zero("midreset");
    rst_n = 1'b1;
    do_store(1'b0, 32'h0000_6004, 32'h5A5A_A5A5, SIZE_WORD, 2, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check_val("scoreboard_empty", sbq.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
